// File: rtl/uart_cmd_master.sv
// uart_cmd_master: byte-command bus master on a uart_chip, bridging 'W'/'R' commands to a 16-bit memory port.
// Optional build macro UART_CMD_AUTOINC_EN adds the 'w'/'r' auto-increment opcodes.
`default_nettype none
module uart_cmd_master #(
  parameter logic [7:0] STATUS_ADDR    = 8'h00,
  parameter logic [7:0] DATA_ADDR      = 8'h01,
  parameter int         TIMEOUT_CYCLES = 2_700_000,
  parameter int         TX_GUARD       = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  AB,
  output logic [7:0]  DO,
  input  logic [7:0]  DI,
  output logic        CS,
  output logic        WE,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [7:0]  OP_W       = 8'h57;
  localparam logic [7:0]  OP_R       = 8'h52;
`ifdef UART_CMD_AUTOINC_EN
  localparam logic [7:0]  OP_WI      = 8'h77;
  localparam logic [7:0]  OP_RI      = 8'h72;
`endif
  localparam logic [7:0]  RPL_OK     = 8'h2E;
  localparam logic [7:0]  RPL_ERR    = 8'h3F;
  localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(TX_GUARD);

  typedef enum logic [3:0] {
    S_RX_POLL, S_RX_PWAIT, S_RX_PCHK, S_RX_READ, S_RX_RWAIT, S_DECODE,
    S_MEM, S_MEM_WAIT, S_MEM_LATCH,
    S_TX_POLL, S_TX_PWAIT, S_TX_PCHK, S_TX_WRITE, S_TX_GUARD
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_op;
  logic [7:0]  r_buf1;
  logic [7:0]  r_buf2;
  logic [7:0]  r_buf3;
  logic [7:0]  r_reply;
  logic [23:0] r_tmo;
  logic [7:0]  r_guard;
`ifdef UART_CMD_AUTOINC_EN
  logic [15:0] r_last_addr;
`endif

  logic [7:0]  w_op;
  logic        w_known;
  logic [1:0]  w_last_idx;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_is_wr;

  // The opcode byte is still on DI while the first byte is being decoded.
  assign w_op = (r_cnt == 2'd0) ? DI : r_op;

  always_comb begin
    w_known    = 1'b1;
    w_last_idx = 2'd0;
    case (w_op)
      OP_W:    w_last_idx = 2'd3;
      OP_R:    w_last_idx = 2'd2;
`ifdef UART_CMD_AUTOINC_EN
      OP_WI:   w_last_idx = 2'd1;
      OP_RI:   w_last_idx = 2'd0;
`endif
      default: w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_addr  = {r_buf1, r_buf2};
    w_wdata = r_buf3;
    w_is_wr = (r_op == OP_W);
`ifdef UART_CMD_AUTOINC_EN
    if (r_op == OP_WI || r_op == OP_RI) begin
      w_addr  = r_last_addr + 16'd1;
      w_wdata = r_buf1;
      w_is_wr = (r_op == OP_WI);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RX_POLL;
      AB          <= '0;
      DO          <= '0;
      CS          <= 1'b0;
      WE          <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_buf1      <= '0;
      r_buf2      <= '0;
      r_buf3      <= '0;
      r_reply     <= '0;
      r_tmo       <= '0;
      r_guard     <= '0;
`ifdef UART_CMD_AUTOINC_EN
      r_last_addr <= '0;
`endif
    end else begin
      cmd_err <= 1'b0;
      if (r_state == S_DECODE || r_cnt == 2'd0)
        r_tmo <= '0;
      else if (r_tmo != TMO_LAST)
        r_tmo <= r_tmo + 24'd1;

      case (r_state)
        S_RX_POLL: begin
          CS <= 1'b1; WE <= 1'b0; AB <= STATUS_ADDR;
          r_state <= S_RX_PWAIT;
        end
        S_RX_PWAIT: begin
          CS <= 1'b0;
          r_state <= S_RX_PCHK;
        end
        S_RX_PCHK: begin
          // A pending byte beats an expiring timeout.
          if (DI[0]) begin
            r_state <= S_RX_READ;
          end else if (r_cnt != 2'd0 && r_tmo == TMO_LAST) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            cmd_err <= 1'b1;
            r_state <= S_RX_POLL;
          end else begin
            r_state <= S_RX_POLL;
          end
        end
        S_RX_READ: begin
          CS <= 1'b1; WE <= 1'b0; AB <= DATA_ADDR;
          r_state <= S_RX_RWAIT;
        end
        S_RX_RWAIT: begin
          CS <= 1'b0;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          busy <= 1'b1;
          case (r_cnt)
            2'd0:    r_op   <= DI;
            2'd1:    r_buf1 <= DI;
            2'd2:    r_buf2 <= DI;
            default: r_buf3 <= DI;
          endcase
          if (!w_known) begin
            cmd_err <= 1'b1;
            r_reply <= RPL_ERR;
            r_cnt   <= '0;
            r_state <= S_TX_POLL;
          end else if (r_cnt == w_last_idx) begin
            r_cnt   <= '0;
            r_state <= S_MEM;
          end else begin
            r_cnt   <= r_cnt + 2'd1;
            r_state <= S_RX_POLL;
          end
        end
        S_MEM: begin
          mem_en    <= 1'b1;
          mem_we    <= w_is_wr;
          mem_addr  <= w_addr;
          mem_wdata <= w_wdata;
          r_reply   <= RPL_OK;
`ifdef UART_CMD_AUTOINC_EN
          r_last_addr <= w_addr;
`endif
          r_state   <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_state <= mem_we ? S_TX_POLL : S_MEM_LATCH;
        end
        S_MEM_LATCH: begin
          r_reply <= mem_rdata;
          r_state <= S_TX_POLL;
        end
        S_TX_POLL: begin
          CS <= 1'b1; WE <= 1'b0; AB <= STATUS_ADDR;
          r_state <= S_TX_PWAIT;
        end
        S_TX_PWAIT: begin
          CS <= 1'b0;
          r_state <= S_TX_PCHK;
        end
        S_TX_PCHK: begin
          r_state <= DI[1] ? S_TX_POLL : S_TX_WRITE;
        end
        S_TX_WRITE: begin
          CS <= 1'b1; WE <= 1'b1; AB <= DATA_ADDR; DO <= r_reply;
          r_guard <= '0;
          r_state <= S_TX_GUARD;
        end
        S_TX_GUARD: begin
          CS <= 1'b0;
          WE <= 1'b0;
          if (r_guard == GUARD_LAST) begin
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RX_POLL;
          end else begin
            r_guard <= r_guard + 8'd1;
          end
        end
        default: r_state <= S_RX_POLL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed bench with a uart_chip register model and a registered memory model.
`default_nettype none
module tb_uart_cmd_master;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  AB, DO;
  logic [7:0]  DI = 8'h00;
  logic        CS, WE;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_en, mem_we, busy, cmd_err;

  always #5 clk = ~clk;

  uart_cmd_master #(
    .STATUS_ADDR(8'h00), .DATA_ADDR(8'h01), .TIMEOUT_CYCLES(TMO), .TX_GUARD(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .AB(AB), .DO(DO), .DI(DI), .CS(CS), .WE(WE),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .busy(busy), .cmd_err(cmd_err)
  );

  // Stimulus side (written only by the initial block)
  logic [7:0]  rx_buf [0:255];
  int          rx_wr = 0;
  logic        hold_tx = 1'b0;
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;

  // Model / monitor side (written only by the always block)
  logic [7:0]  mem [0:65535];
  int          rx_rd = 0;
  int          tx_busy_cnt = 0;
  logic        cs_q = 1'b0;
  int          n_tx = 0, n_wr = 0, n_rd = 0, n_err = 0, n_stat = 0, n_busy = 0, n_csdbl = 0;
  logic [7:0]  last_tx = 8'h00, last_wdata = 8'h00;
  logic [15:0] last_waddr = 16'h0000, last_raddr = 16'h0000;

  always @(posedge clk) begin
    cs_q <= CS;
    if (CS && cs_q) n_csdbl <= n_csdbl + 1;
    if (cmd_err) n_err <= n_err + 1;
    if (busy) n_busy <= n_busy + 1;
    if (tx_busy_cnt != 0) tx_busy_cnt <= tx_busy_cnt - 1;
    if (CS && !WE) begin
      if (AB == 8'h00) begin
        DI     <= {6'd0, (tx_busy_cnt != 0) || hold_tx, rx_rd != rx_wr};
        n_stat <= n_stat + 1;
      end else if (AB == 8'h01) begin
        DI <= rx_buf[rx_rd[7:0]];
        if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
      end
    end
    if (CS && WE && AB == 8'h01) begin
      n_tx        <= n_tx + 1;
      last_tx     <= DO;
      tx_busy_cnt <= 4;
    end
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        n_wr       <= n_wr + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
      end else begin
        mem_rdata  <= mem[mem_addr];
        n_rd       <= n_rd + 1;
        last_raddr <= mem_addr;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int b_tx, b_wr, b_rd, b_err, b_stat, b_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_buf[rx_wr[7:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_tx = n_tx; b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_stat = n_stat; b_busy = n_busy;
  endtask

  function automatic logic [63:0] outs();
    return 64'({AB, DO, CS, WE, mem_addr, mem_wdata, mem_en, mem_we, busy, cmd_err});
  endfunction

  initial begin
    run(3);
    check("reset_outputs", outs(), 64'h0);
    reset_n = 1'b1;
    pre_en = 1'b1; pre_addr = 16'h00FF; pre_data = 8'h3C;
    run(1);
    pre_addr = 16'h0000; pre_data = 8'h5A;
    run(1);
    pre_addr = 16'hFFFF; pre_data = 8'hC3;
    run(1);
    pre_en = 1'b0;

    // Write command
    snap();
    push(8'h57); push(8'h12); push(8'h34); push(8'hA5);
    run(150);
    check("w_memwr_cnt", 64'(n_wr - b_wr), 64'd1);
    check("w_addr", 64'(last_waddr), 64'h1234);
    check("w_data", 64'(last_wdata), 64'hA5);
    check("w_memrd_cnt", 64'(n_rd - b_rd), 64'd0);
    check("w_tx_cnt", 64'(n_tx - b_tx), 64'd1);
    check("w_reply", 64'(last_tx), 64'h2E);
    check("w_err_cnt", 64'(n_err - b_err), 64'd0);

    // Read command, busy during and after
    snap();
    push(8'h52); push(8'h00); push(8'hFF);
    run(14);
    check("r_busy_mid", 64'(busy), 64'd1);
    run(150);
    check("r_memrd_cnt", 64'(n_rd - b_rd), 64'd1);
    check("r_addr", 64'(last_raddr), 64'h00FF);
    check("r_tx_cnt", 64'(n_tx - b_tx), 64'd1);
    check("r_reply", 64'(last_tx), 64'h3C);
    check("r_busy_end", 64'(busy), 64'd0);

    // Unknown opcode
    snap();
    push(8'h41);
    run(100);
    check("bad_err_cnt", 64'(n_err - b_err), 64'd1);
    check("bad_reply", 64'(last_tx), 64'h3F);
    check("bad_tx_cnt", 64'(n_tx - b_tx), 64'd1);
    check("bad_mem_cnt", 64'((n_wr - b_wr) + (n_rd - b_rd)), 64'd0);

    // Partial command then timeout, followed by a normal read
    snap();
    push(8'h57); push(8'h12);
    run(TMO + 100);
    check("tmo_err_cnt", 64'(n_err - b_err), 64'd1);
    check("tmo_tx_cnt", 64'(n_tx - b_tx), 64'd0);
    check("tmo_mem_cnt", 64'((n_wr - b_wr) + (n_rd - b_rd)), 64'd0);
    check("tmo_busy", 64'(busy), 64'd0);
    snap();
    push(8'h52); push(8'h12); push(8'h34);
    run(150);
    check("tmo_rd_addr", 64'(last_raddr), 64'h1234);
    check("tmo_rd_reply", 64'(last_tx), 64'hA5);
    check("tmo_rd_err", 64'(n_err - b_err), 64'd0);

`ifdef UART_CMD_AUTOINC_EN
    snap();
    push(8'h52); push(8'hFF); push(8'hFF);
    run(150);
    check("ai_seed_addr", 64'(last_raddr), 64'hFFFF);
    check("ai_seed_reply", 64'(last_tx), 64'hC3);
    push(8'h72);
    run(100);
    check("ai_rd_cnt", 64'(n_rd - b_rd), 64'd2);
    check("ai_rd_addr", 64'(last_raddr), 64'h0000);
    check("ai_rd_reply", 64'(last_tx), 64'h5A);
    push(8'h77); push(8'h66);
    run(100);
    check("ai_wr_addr", 64'(last_waddr), 64'h0001);
    check("ai_wr_data", 64'(last_wdata), 64'h66);
    check("ai_wr_reply", 64'(last_tx), 64'h2E);
    check("ai_err_cnt", 64'(n_err - b_err), 64'd0);
`else
    snap();
    push(8'h72);
    run(100);
    check("r_lc_err_cnt", 64'(n_err - b_err), 64'd1);
    check("r_lc_reply", 64'(last_tx), 64'h3F);
    check("r_lc_mem_cnt", 64'((n_wr - b_wr) + (n_rd - b_rd)), 64'd0);
`endif

    // Reset while stuck in TX polling
    hold_tx = 1'b1;
    snap();
    push(8'h57); push(8'hAB); push(8'hCD); push(8'h11);
    for (int i = 0; i < 200 && n_wr == b_wr; i++) @(negedge clk);
    run(10);
    check("rst_memwr_cnt", 64'(n_wr - b_wr), 64'd1);
    check("rst_tx_held", 64'(n_tx - b_tx), 64'd0);
    check("rst_busy_before", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 check("rst_async_outputs", outs(), 64'h0);
    hold_tx = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    snap();
    run(100);
    check("rst_no_tx", 64'(n_tx - b_tx), 64'd0);
    check("rst_polls", 64'(n_stat - b_stat > 0), 64'd1);
    check("rst_no_mem", 64'((n_wr - b_wr) + (n_rd - b_rd)), 64'd0);
    check("rst_idle_busy", 64'(n_busy - b_busy), 64'd0);

    check("cs_back_to_back", 64'(n_csdbl), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
